instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 49 ++++
 rtl/instr_field_pack.sv | 66 ++++++
 rtl/instr_encoder.sv | 115 +++++++++++
 tb/tb_instr_encoder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared encodings for the instruction encoder: request classes, FSM states,
// RV32I opcodes and funct3 legality tables.
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_IALU   = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8
  } instr_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FULL
  } enc_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  // Bit n set means funct3 == n is legal for that class.
  localparam logic [7:0] R_ALT_F3_OK  = 8'b0010_0001;
  localparam logic [7:0] LOAD_F3_OK   = 8'b0011_0111;
  localparam logic [7:0] STORE_F3_OK  = 8'b0000_0111;
  localparam logic [7:0] BRANCH_F3_OK = 8'b1111_0011;
  localparam logic [7:0] JALR_F3_OK   = 8'b0000_0001;

  function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
    logic signed [31:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational RV32I field packing and request legality check.
module instr_field_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  logic       shift;
  logic [6:0] f7;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    f7      = '0;
    shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
    case (instr_class_t'(cls))
      CLS_R: begin
        f7      = (alt && (funct3 == 3'b000 || funct3 == 3'b101)) ? FUNCT7_ALT : 7'b0;
        word    = {f7, rs2, rs1, funct3, rd, OP_R};
        illegal = alt && !R_ALT_F3_OK[funct3];
      end
      CLS_IALU: begin
        if (shift) begin
          f7      = (alt && funct3 == 3'b101) ? FUNCT7_ALT : 7'b0;
          word    = {f7, imm[4:0], rs1, funct3, rd, OP_IALU};
          illegal = (imm[31:5] != '0);
        end else begin
          word    = {imm[11:0], rs1, funct3, rd, OP_IALU};
          illegal = !fits_signed(imm, 12);
        end
      end
      CLS_LOAD: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        illegal = !LOAD_F3_OK[funct3] || !fits_signed(imm, 12);
      end
      CLS_STORE: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        illegal = !STORE_F3_OK[funct3] || !fits_signed(imm, 12);
      end
      CLS_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        illegal = !BRANCH_F3_OK[funct3] || !fits_signed(imm, 13) || imm[0];
      end
      CLS_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        illegal = !fits_signed(imm, 21) || imm[0];
      end
      CLS_JALR: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_JALR};
        illegal = !JALR_F3_OK[funct3] || !fits_signed(imm, 12);
      end
      CLS_LUI:   word = {imm[31:12], rd, OP_LUI};
      CLS_AUIPC: word = {imm[31:12], rd, OP_AUIPC};
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded requests, packs them into RV32I words
// and streams them into instruction memory from address 0.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          finish,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_class,
  input  logic [2:0]    in_funct3,
  input  logic          in_alt,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [31:0]   in_imm,
  output logic          mem_we,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          busy,
  output logic          full,
  output logic          err,
  output logic [AW-2:0] word_count
);

  localparam int unsigned LAST = DEPTH - 1;

  enc_state_t  state, state_nx;
  logic [31:0] pack_word;
  logic        pack_illegal;
  logic        last_pending;
  logic        wr_done;
  logic        accept;

  instr_field_pack u_pack (
    .cls     (in_class),
    .funct3  (in_funct3),
    .alt     (in_alt),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .imm     (in_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  assign last_pending = mem_we && (mem_addr[AW-1:2] == LAST[AW-3:0]);
  assign wr_done      = mem_we && mem_ready;
  assign accept       = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN: begin
        busy     = 1'b1;
        in_ready = (!mem_we || mem_ready) && !last_pending;
        if (finish)                       state_nx = ST_DRAIN;
        else if (wr_done && last_pending) state_nx = ST_FULL;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!mem_we || mem_ready) state_nx = ST_IDLE;
      end
      ST_FULL: if (finish) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // mem_addr always names the pending (or next) word; it stays on the last
  // word once the memory fills so it can never wrap back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      word_count <= '0;
      full       <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (wr_done) begin
        word_count <= word_count + (AW-1)'(1);
        if (last_pending) full <= 1'b1;
        else              mem_addr <= mem_addr + AW'(4);
      end
      if (accept && !pack_illegal) begin
        mem_we    <= 1'b1;
        mem_wdata <= pack_word;
      end else if (wr_done) begin
        mem_we <= 1'b0;
      end
      if (accept && pack_illegal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding vector table plus multi-cycle
// sequences for stalls, fill-up, illegal requests, finish and reset.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH) + 2;

  logic          clk = 1'b0;
  logic          rst, start, finish, in_valid, in_ready, in_alt;
  logic [3:0]    in_class;
  logic [2:0]    in_funct3;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [31:0]   in_imm;
  logic          mem_we, mem_ready, busy, full, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW-2:0] word_count;

  int nchecks = 0;
  int nfail   = 0;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_class   (in_class),
    .in_funct3  (in_funct3),
    .in_alt     (in_alt),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .full       (full),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        bad;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string n, input logic [3:0] c, input logic [2:0] f3,
                              input logic alt, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic bad, input logic [31:0] word);
    vec_t v;
    v.name = n; v.cls = c; v.f3 = f3; v.alt = alt; v.rd = rd; v.rs1 = rs1;
    v.rs2 = rs2; v.imm = imm; v.bad = bad; v.word = word;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    in_class = c; in_funct3 = f3; in_alt = alt;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
  endtask

  // One request per session: start, accept, inspect, finish and drain.
  task automatic run_vec(input vec_t t);
    start = 1'b1; tick(); start = 1'b0;
    drive(t.cls, t.f3, t.alt, t.rd, t.rs1, t.rs2, t.imm);
    mem_ready = 1'b1;
    #1 chk({t.name, " ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({t.name, " we"}, mem_we, !t.bad);
    chk({t.name, " err"}, err, t.bad);
    if (!t.bad) chk({t.name, " word"}, mem_wdata, t.word);
    finish = 1'b1; tick(); finish = 1'b0;
    tick(); tick();
    chk({t.name, " idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; mem_ready = 1'b1;
    in_valid = 1'b0; in_class = '0; in_funct3 = '0; in_alt = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

    vecs.push_back(mk("addi",     CLS_IALU,   3'b000, 0, 1, 0, 0, 32'd5,        0, 32'h00500093));
    vecs.push_back(mk("add",      CLS_R,      3'b000, 0, 3, 1, 2, 32'd0,        0, 32'h002081B3));
    vecs.push_back(mk("sub",      CLS_R,      3'b000, 1, 3, 1, 2, 32'd0,        0, 32'h402081B3));
    vecs.push_back(mk("beq",      CLS_BRANCH, 3'b000, 0, 0, 1, 2, 32'd8,        0, 32'h00208463));
    vecs.push_back(mk("jal",      CLS_JAL,    3'b000, 0, 1, 0, 0, 32'd16,       0, 32'h010000EF));
    vecs.push_back(mk("lui",      CLS_LUI,    3'b000, 0, 5, 0, 0, 32'h12345000, 0, 32'h123452B7));
    vecs.push_back(mk("srai",     CLS_IALU,   3'b101, 1, 1, 2, 0, 32'd3,        0, 32'h40315093));
    vecs.push_back(mk("sw",       CLS_STORE,  3'b010, 0, 0, 2, 5, 32'hFFFFFFFC, 0, 32'hFE512E23));
    vecs.push_back(mk("lw_max",   CLS_LOAD,   3'b010, 0, 6, 1, 0, 32'd2047,     0, 32'h7FF0A303));
    vecs.push_back(mk("jalr",     CLS_JALR,   3'b000, 0, 0, 1, 0, 32'd0,        0, 32'h00008067));
    vecs.push_back(mk("auipc",    CLS_AUIPC,  3'b000, 0, 1, 0, 0, 32'hFFFFF000, 0, 32'hFFFFF097));
    vecs.push_back(mk("bne_min",  CLS_BRANCH, 3'b001, 0, 0, 1, 2, 32'hFFFFF000, 0, 32'h80209063));
    vecs.push_back(mk("addi_min", CLS_IALU,   3'b000, 0, 1, 0, 0, 32'hFFFFF800, 0, 32'h80000093));
    vecs.push_back(mk("jal_min",  CLS_JAL,    3'b000, 0, 0, 0, 0, 32'hFFF00000, 0, 32'h8000006F));
    vecs.push_back(mk("jal_max",  CLS_JAL,    3'b000, 0, 0, 0, 0, 32'h000FFFFE, 0, 32'h7FFFF06F));
    vecs.push_back(mk("b_odd",    CLS_BRANCH, 3'b000, 0, 0, 1, 2, 32'd7,        1, 32'h0));
    vecs.push_back(mk("b_far",    CLS_BRANCH, 3'b000, 0, 0, 1, 2, 32'd4096,     1, 32'h0));
    vecs.push_back(mk("b_f3",     CLS_BRANCH, 3'b010, 0, 0, 1, 2, 32'd8,        1, 32'h0));
    vecs.push_back(mk("ld_f3",    CLS_LOAD,   3'b011, 0, 1, 1, 0, 32'd0,        1, 32'h0));
    vecs.push_back(mk("st_f3",    CLS_STORE,  3'b011, 0, 0, 1, 2, 32'd0,        1, 32'h0));
    vecs.push_back(mk("jalr_f3",  CLS_JALR,   3'b001, 0, 1, 1, 0, 32'd0,        1, 32'h0));
    vecs.push_back(mk("addi_big", CLS_IALU,   3'b000, 0, 1, 0, 0, 32'd2048,     1, 32'h0));
    vecs.push_back(mk("slli_big", CLS_IALU,   3'b001, 0, 1, 1, 0, 32'd32,       1, 32'h0));
    vecs.push_back(mk("r_altf3",  CLS_R,      3'b001, 1, 1, 1, 2, 32'd0,        1, 32'h0));
    vecs.push_back(mk("jal_far",  CLS_JAL,    3'b000, 0, 1, 0, 0, 32'h00100000, 1, 32'h0));

    tick(); tick();
    rst = 1'b0;
    chk("rst we", mem_we, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst count", word_count, 0);
    chk("rst full/err", {full, err}, 0);
    chk("rst ready/busy", {in_ready, busy}, 0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back, ignored start, illegal skip, stall, then fill to DEPTH.
    start = 1'b1; tick(); start = 1'b0;
    drive(CLS_R, 3'b000, 0, 3, 1, 2, 0); mem_ready = 1'b1;
    tick();
    chk("b2b addr0", mem_addr, 0);
    chk("b2b word0", mem_wdata, 32'h002081B3);
    in_alt = 1'b1;
    tick();
    chk("b2b addr1", mem_addr, 4);
    chk("b2b word1", mem_wdata, 32'h402081B3);
    chk("b2b count", word_count, 1);
    drive(CLS_BRANCH, 3'b000, 0, 0, 1, 2, 32'd7); start = 1'b1;
    tick(); start = 1'b0;
    chk("ill we", mem_we, 0);
    chk("ill err", err, 1);
    chk("ill count", word_count, 2);
    chk("ill addr", mem_addr, 8);
    chk("start ignored", busy, 1);
    drive(CLS_IALU, 3'b000, 0, 1, 0, 0, 32'd5);
    tick();
    chk("next addr", mem_addr, 8);
    chk("next word", mem_wdata, 32'h00500093);
    drive(CLS_LUI, 3'b000, 0, 5, 0, 0, 32'h12345000); mem_ready = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      chk("stall ready", in_ready, 0);
      chk("stall hold", {mem_we, mem_addr, mem_wdata}, {1'b1, 4'h8, 32'h00500093});
    end
    mem_ready = 1'b1;
    #1 chk("unstall ready", in_ready, 1);
    tick();
    chk("last addr", mem_addr, 12);
    chk("last word", mem_wdata, 32'h123452B7);
    chk("last count", word_count, 3);
    drive(CLS_JAL, 3'b000, 0, 1, 0, 0, 32'd16);
    #1 chk("last_pending ready", in_ready, 0);
    tick();
    chk("full", full, 1);
    chk("full count", word_count, 4);
    chk("full we", mem_we, 0);
    chk("full ready", in_ready, 0);
    tick();
    chk("fifth dropped", {mem_we, word_count}, {1'b0, 3'd4});
    in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0;
    chk("full->idle", {busy, full, err}, 3'b011);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart clears", {full, err, word_count}, 0);
    chk("restart busy", busy, 1);
    finish = 1'b1; tick(); finish = 1'b0; tick();

    // finish in the same cycle as an accept still writes that word.
    start = 1'b1; tick(); start = 1'b0;
    drive(CLS_IALU, 3'b000, 0, 1, 0, 0, 32'd5); finish = 1'b1; mem_ready = 1'b0;
    tick(); in_valid = 1'b0; finish = 1'b0;
    chk("fin we", mem_we, 1);
    tick();
    chk("fin drain busy", busy, 1);
    mem_ready = 1'b1;
    tick();
    chk("fin drained", {busy, mem_we, word_count}, {1'b0, 1'b0, 3'd1});

    // Reset mid-session drops the pending write.
    start = 1'b1; tick(); start = 1'b0;
    drive(CLS_IALU, 3'b000, 0, 1, 0, 0, 32'd5);
    tick(); tick();
    in_valid = 1'b0; mem_ready = 1'b0;
    chk("pre-rst", {mem_we, word_count}, {1'b1, 3'd1});
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst mid we", mem_we, 0);
    chk("rst mid state", {busy, word_count, mem_addr}, 0);
    mem_ready = 1'b1; tick();
    chk("rst no reissue", mem_we, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
